ball_engine: RTL and testbench

- Ball motion and collision stage for the pong game; directly downstream of the paddle state machine.
- Consumes the paddle's inclusive column span (state_left..state_right) and moves a one-cell ball on a COLS x ROWS grid.
- Reflects the ball off the side walls, the top wall and the paddle, counts paddle hits, and flags a miss.
- Outputs feed the display/render stage.

---
 rtl/ball_engine_if.sv | 30 +++
 rtl/ball_engine.sv | 209 ++++++++++++++++++++
 tb/tb_ball_engine.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ball_engine_if.sv
// Paddle span and enable in, ball position, hit/miss pulses, score and run status out.
// Latency: none (signal bundle only).
// Backpressure: none; every signal is a plain level or a one-clock pulse.
interface ball_engine_if #(
   parameter int BIT_WIDTH  = 3,
   parameter int ROW_BITS   = 3,
   parameter int SCORE_BITS = 8
);
   logic                  en;
   logic [BIT_WIDTH-1:0]  state_left;
   logic [BIT_WIDTH-1:0]  state_right;
   logic [BIT_WIDTH-1:0]  ball_x;
   logic [ROW_BITS-1:0]   ball_y;
   logic                  hit;
   logic                  miss;
   logic [SCORE_BITS-1:0] score;
   logic                  running;

   // Paddle/game-control side drives the inputs and watches the ball.
   modport master (
      output en, state_left, state_right,
      input  ball_x, ball_y, hit, miss, score, running
   );

   // The ball engine itself.
   modport slave (
      input  en, state_left, state_right,
      output ball_x, ball_y, hit, miss, score, running
   );
endinterface

// File: rtl/ball_engine.sv
// Ball motion/collision: moves one ball cell per TICK_DIV clocks, reflects off walls and paddle, counts hits.
// Latency: position, hit and miss register on the tick edge and are visible the following cycle.
// Backpressure: none; free-running. Optional BALL_AUTO_SERVE_EN re-serves 4 ticks after a miss.
module ball_engine #(
   parameter int BIT_WIDTH  = 3,
   parameter int COLS       = 6,
   parameter int ROWS       = 8,
   parameter int ROW_BITS   = 3,
   parameter int START_X    = 2,
   parameter int TICK_DIV   = 4,
   parameter int SCORE_BITS = 8
) (
   input logic         clk,
   input logic         rst_n,
   ball_engine_if.slave bus
);
   localparam int CNT_BITS = $clog2(TICK_DIV);

   localparam logic [BIT_WIDTH-1:0]  X_START   = BIT_WIDTH'(START_X);
   localparam logic [BIT_WIDTH-1:0]  X_MAX     = BIT_WIDTH'(COLS - 1);
   localparam logic [BIT_WIDTH-1:0]  X_ONE     = BIT_WIDTH'(1);
   localparam logic [ROW_BITS-1:0]   Y_CHK     = ROW_BITS'(ROWS - 2);
   localparam logic [ROW_BITS-1:0]   Y_HIT     = ROW_BITS'(ROWS - 3);
   localparam logic [ROW_BITS-1:0]   Y_BOT     = ROW_BITS'(ROWS - 1);
   localparam logic [ROW_BITS-1:0]   Y_ONE     = ROW_BITS'(1);
   localparam logic [CNT_BITS-1:0]   CNT_MAX   = CNT_BITS'(TICK_DIV - 1);
   localparam logic [CNT_BITS-1:0]   CNT_ONE   = CNT_BITS'(1);
   localparam logic [SCORE_BITS-1:0] SCORE_MAX = '1;
   localparam logic [SCORE_BITS-1:0] SCORE_ONE = SCORE_BITS'(1);

   typedef enum logic [1:0] {IDLE, SERVE, RUN, MISS} state_t;

   state_t                state_q, state_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   logic [BIT_WIDTH-1:0]  x_q, x_d;
   logic [ROW_BITS-1:0]   y_q, y_d;
   logic                  dx_q, dx_d;     // 1 = moving right
   logic                  dy_q, dy_d;     // 1 = moving down
   logic [SCORE_BITS-1:0] score_q, score_d;
   logic                  hit_q, hit_d;
   logic                  miss_q, miss_d;

   // Candidate move for the current position; only committed on a RUN tick.
   logic [BIT_WIDTH-1:0]  nx;
   logic [ROW_BITS-1:0]   ny;
   logic                  dx_mv, dy_mv, hit_mv, miss_mv;
   logic                  tick;

`ifdef BALL_AUTO_SERVE_EN
   logic [1:0]            mt_q, mt_d;     // ticks spent in MISS before re-serve
`endif

   assign tick = (cnt_q == CNT_MAX);

   // Next-position calculation: horizontal reflection first, then the paddle test uses the reflected column.
   always_comb begin
      nx      = x_q + X_ONE;
      ny      = y_q;
      dx_mv   = dx_q;
      dy_mv   = dy_q;
      hit_mv  = 1'b0;
      miss_mv = 1'b0;
      if (dx_q && (x_q == X_MAX)) begin
         dx_mv = 1'b0;
         nx    = X_MAX - X_ONE;
      end else if (!dx_q && (x_q == '0)) begin
         dx_mv = 1'b1;
         nx    = X_ONE;
      end else if (!dx_q) begin
         nx = x_q - X_ONE;
      end
      if (!dy_q) begin
         if (y_q == '0) begin
            dy_mv = 1'b1;
            ny    = Y_ONE;
         end else begin
            ny = y_q - Y_ONE;
         end
      end else if (y_q < Y_CHK) begin
         ny = y_q + Y_ONE;
      end else if ((bus.state_left <= nx) && (nx <= bus.state_right)) begin
         // An inverted span (left > right) can never satisfy this, so it always misses.
         dy_mv  = 1'b0;
         ny     = Y_HIT;
         hit_mv = 1'b1;
      end else begin
         ny      = Y_BOT;
         miss_mv = 1'b1;
      end
   end

   // FSM next state, tick counter and datapath updates; en low overrides everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      score_d = score_q;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
`ifdef BALL_AUTO_SERVE_EN
      mt_d    = mt_q;
`endif
      if (state_q != IDLE) begin
         cnt_d = tick ? '0 : cnt_q + CNT_ONE;
      end
      if (!bus.en) begin
         state_d = IDLE;
         cnt_d   = '0;
         x_d     = X_START;
         y_d     = '0;
         dx_d    = 1'b1;
         dy_d    = 1'b1;
         score_d = '0;
`ifdef BALL_AUTO_SERVE_EN
         mt_d    = '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_d = SERVE;
               cnt_d   = '0;
            end
            SERVE: begin
               if (tick) state_d = RUN;
            end
            RUN: begin
               if (tick) begin
                  x_d    = nx;
                  y_d    = ny;
                  dx_d   = dx_mv;
                  dy_d   = dy_mv;
                  hit_d  = hit_mv;
                  miss_d = miss_mv;
                  if (hit_mv && (score_q != SCORE_MAX)) score_d = score_q + SCORE_ONE;
                  if (miss_mv) begin
                     state_d = MISS;
`ifdef BALL_AUTO_SERVE_EN
                     mt_d    = '0;
`endif
                  end
               end
            end
            MISS: begin
`ifdef BALL_AUTO_SERVE_EN
               // Fourth tick re-serves; the counter wraps to 0 on that same tick.
               if (tick) begin
                  if (mt_q == 2'd3) begin
                     state_d = SERVE;
                     x_d     = X_START;
                     y_d     = '0;
                     dx_d    = 1'b1;
                     dy_d    = 1'b1;
                     mt_d    = '0;
                  end else begin
                     mt_d = mt_q + 2'd1;
                  end
               end
`else
               state_d = MISS;
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x_q     <= X_START;
         y_q     <= '0;
         dx_q    <= 1'b1;
         dy_q    <= 1'b1;
         score_q <= '0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         score_q <= score_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

`ifdef BALL_AUTO_SERVE_EN
   // Miss-delay tick counter for the automatic re-serve.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mt_q <= '0;
      else        mt_q <= mt_d;
   end
`endif

   assign bus.ball_x  = x_q;
   assign bus.ball_y  = y_q;
   assign bus.hit     = hit_q;
   assign bus.miss    = miss_q;
   assign bus.score   = score_q;
   assign bus.running = (state_q == RUN);
endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: directed vector table, hand-written saturation/async-reset sequences, random run vs model.
// Latency: expects registered outputs one cycle after each move tick.
// Backpressure: none exercised; the DUT is free-running.
module tb_ball_engine;
   localparam int COLS     = 6;
   localparam int ROWS     = 8;
   localparam int START_X  = 2;
   localparam int TD       = 4;
   localparam int PH_IDLE  = 0;
   localparam int PH_SERVE = 1;
   localparam int PH_RUN   = 2;
   localparam int PH_MISS  = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       en    = 1'b0;
   logic [2:0] sl    = 3'd0;
   logic [2:0] sr    = 3'd0;

   int errors = 0;
   int checks = 0;

   ball_engine_if #(.BIT_WIDTH(3), .ROW_BITS(3), .SCORE_BITS(8)) bus ();
   ball_engine_if #(.BIT_WIDTH(3), .ROW_BITS(3), .SCORE_BITS(2)) bus2 ();

   assign bus.en           = en;
   assign bus.state_left   = sl;
   assign bus.state_right  = sr;
   assign bus2.en          = en;
   assign bus2.state_left  = sl;
   assign bus2.state_right = sr;

   ball_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   ball_engine #(.SCORE_BITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   always #5 clk = ~clk;

   typedef struct {
      bit en;
      int sl, sr, n;
      int x, y, hit, miss, score, run;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit e, int a, int b, int n, int x, int y, int h, int m, int s, int r);
      vec_t v;
      v.en = e; v.sl = a; v.sr = b; v.n = n;
      v.x = x; v.y = y; v.hit = h; v.miss = m; v.score = s; v.run = r;
      return v;
   endfunction

   function automatic int sat3(int v);
      return (v > 3) ? 3 : v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input int x, input int y, input int h, input int m,
                          input int s, input int r);
      chk({nm, ".x"},      32'(bus.ball_x),  x);
      chk({nm, ".y"},      32'(bus.ball_y),  y);
      chk({nm, ".hit"},    32'(bus.hit),     h);
      chk({nm, ".miss"},   32'(bus.miss),    m);
      chk({nm, ".score"},  32'(bus.score),   s);
      chk({nm, ".run"},    32'(bus.running), r);
      chk({nm, ".score2"}, 32'(bus2.score),  sat3(s));
   endtask

   // Behavioural reference: integer position and signed velocity, reflection by overshoot.
   int m_phase, m_cnt, m_x, m_y, m_vx, m_vy, m_score, m_hit, m_miss, m_mt;

   task automatic model_reset();
      m_phase = PH_IDLE; m_cnt = 0; m_x = START_X; m_y = 0;
      m_vx = 1; m_vy = 1; m_score = 0; m_hit = 0; m_miss = 0; m_mt = 0;
   endtask

   task automatic model_move(input int a, input int b);
      int nx, ny;
      nx = m_x + m_vx;
      if (nx < 0 || nx > COLS - 1) begin
         m_vx = -m_vx;
         nx   = m_x + m_vx;
      end
      ny = m_y + m_vy;
      if (ny < 0) begin
         m_vy = 1;
         ny   = 1;
      end else if (m_vy > 0 && ny == ROWS - 1) begin
         if (a <= nx && nx <= b) begin
            m_vy = -1; ny = ROWS - 3; m_hit = 1;
            m_score = (m_score >= 255) ? 255 : m_score + 1;
         end else begin
            m_miss = 1; m_phase = PH_MISS; m_mt = 0;
         end
      end
      m_x = nx;
      m_y = ny;
   endtask

   task automatic model_step(input bit e, input int a, input int b);
      bit tk;
      m_hit = 0; m_miss = 0;
      tk = (m_cnt == TD - 1);
      if (!e) begin
         model_reset();
      end else if (m_phase == PH_IDLE) begin
         m_phase = PH_SERVE; m_cnt = 0;
      end else begin
         m_cnt = (m_cnt + 1) % TD;
         if (tk) begin
            if (m_phase == PH_SERVE) m_phase = PH_RUN;
            else if (m_phase == PH_RUN) model_move(a, b);
`ifdef BALL_AUTO_SERVE_EN
            else if (m_phase == PH_MISS) begin
               m_mt++;
               if (m_mt == 4) begin
                  m_phase = PH_SERVE; m_x = START_X; m_y = 0; m_vx = 1; m_vy = 1; m_mt = 0;
               end
            end
`endif
         end
      end
   endtask

   initial begin
      int k;
      // Directed trajectory from reset; the wall/paddle corner lands on the miss tick.
      tbl.push_back(mk(1, 1, 2,  1, 2, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2,  3, 2, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2,  1, 2, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2,  3, 2, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2,  1, 3, 1, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2,  4, 4, 2, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2,  4, 5, 3, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2,  4, 4, 4, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2,  4, 3, 5, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2,  4, 2, 6, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2,  4, 1, 5, 1, 0, 1, 1));
      tbl.push_back(mk(1, 3, 4,  1, 1, 5, 0, 0, 1, 1));
      tbl.push_back(mk(1, 3, 4,  3, 0, 4, 0, 0, 1, 1));
      tbl.push_back(mk(1, 3, 4,  4, 1, 3, 0, 0, 1, 1));
      tbl.push_back(mk(1, 3, 4, 12, 4, 0, 0, 0, 1, 1));
      tbl.push_back(mk(1, 3, 4,  4, 5, 1, 0, 0, 1, 1));
      tbl.push_back(mk(1, 3, 4,  4, 4, 2, 0, 0, 1, 1));
      tbl.push_back(mk(1, 3, 4, 16, 0, 6, 0, 0, 1, 1));
      tbl.push_back(mk(1, 3, 4,  4, 1, 7, 0, 1, 1, 0));
      tbl.push_back(mk(1, 3, 4,  1, 1, 7, 0, 0, 1, 0));
`ifdef BALL_AUTO_SERVE_EN
      tbl.push_back(mk(1, 3, 4, 20, 2, 0, 0, 0, 1, 1));
`else
      tbl.push_back(mk(1, 3, 4, 20, 1, 7, 0, 0, 1, 0));
`endif
      tbl.push_back(mk(0, 3, 4,  1, 2, 0, 0, 0, 0, 0));

      // Asynchronous reset from time zero.
      #1 rst_n = 1'b0;
      #1 chk_all("reset", 2, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         en = tbl[i].en;
         sl = 3'(tbl[i].sl);
         sr = 3'(tbl[i].sr);
         repeat (tbl[i].n) @(posedge clk);
         @(negedge clk);
         chk_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].hit, tbl[i].miss,
                 tbl[i].score, tbl[i].run);
      end

      // Full-width paddle: every descent hits; 2-bit score saturates at 3.
      en = 1'b1; sl = 3'd0; sr = 3'd5;
      k = 0;
      for (int c = 0; c < 1500 && k < 5; c++) begin
         @(negedge clk);
         if (bus.hit) begin
            k++;
            chk($sformatf("sat_score8_%0d", k), 32'(bus.score), k);
            chk($sformatf("sat_score2_%0d", k), 32'(bus2.score), sat3(k));
         end
      end
      chk("sat_hit_count", k, 5);

      // Asynchronous reset mid-RUN, sampled away from any clock edge.
      @(negedge clk);
      chk("pre_rst_run", 32'(bus.running), 1);
      #2 rst_n = 1'b0;
      #1 chk_all("async_rst", 2, 0, 0, 0, 0, 0);
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Random run against the behavioural model.
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         bit e;
         int a, b;
         e = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 1) == 0) begin
            a = 0; b = 5;
         end else begin
            a = $urandom_range(0, 7); b = $urandom_range(0, 7);
         end
         en = e; sl = 3'(a); sr = 3'(b);
         model_step(e, a, b);
         @(negedge clk);
         chk_all($sformatf("rnd%0d", c), m_x, m_y, m_hit, m_miss, m_score,
                 (m_phase == PH_RUN) ? 1 : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
